selection_sender: RTL
=====================

Name: selection_sender

Overview:
- Transmit end of the selection-storer serial link; the storer is the receiving end.
- Buffers up to FIFO_DEPTH (address, 12-bit word) requests from the host and emits each on the link as a frame:
  - queue select held stable on queue_out;
  - 12 data bits LSB-first on serial_out while data_ctrl_out is high;
  - one active-low display strobe on displaying_trigger_out.
- Sits on the 10 MHz clock domain and drives the storer's data_ctrl_in, serial_in, queue0 and displaying_trigger_in pins directly.

Parameters:
- WORD_W, 12, data bits per frame (storer expects exactly 12).
- ADDR_W, 3, queue select width (8 storer registers).
- FIFO_DEPTH, 4, request buffer entries (power of 2, at least 2).
- SETUP_CYCLES, 2, cycles queue_out is stable before the first data bit (at least 1).
- GAP_CYCLES, 2, idle cycles after the strobe before the next frame (at least 1).

Ports:
- ten_MHz_synch_in  in  1  clock; all logic on posedge.
- reset_in  in  1  reset, asynchronous and active-high.
- load_valid_in  in  1  host request valid.
- load_ready_out  out  1  equals !fifo_full.
- load_addr_in  in  ADDR_W  target register select.
- load_data_in  in  WORD_W  word to send.
- hold_in  in  1  when 1, no new frame starts; a frame in progress completes.
- data_ctrl_out  out  1  framing; high for exactly WORD_W cycles per frame.
- serial_out  out  1  data bit.
- queue_out  out  ADDR_W  register select to the storer.
- displaying_trigger_out  out  1  active-low display strobe; idles high.
- busy_out  out  1  FSM not IDLE.
- fifo_count_out  out  clog2(FIFO_DEPTH)+1  occupied entries.
- overflow_out  out  1  sticky; set when load_valid_in=1 while full. Cleared only by reset.

Behaviour:
- Reset (asynchronous, immediate): data_ctrl_out=0, serial_out=0, queue_out=0, displaying_trigger_out=1, busy_out=0, fifo_count_out=0, overflow_out=0, FSM=IDLE, FIFO flushed.
- Reset mid-frame aborts the frame; the storer sees ctrl fall early, and that outcome is accepted.
- Push handshake:
  - An entry is written on an edge where load_valid_in && load_ready_out.
  - No push while full, even if a pop happens on the same edge.
  - Simultaneous push and pop on a non-full FIFO leaves the count unchanged.
- FSM states: IDLE, SETUP, SHIFT, STROBE, GAP.
- IDLE:
  - If FIFO not empty and hold_in=0: pop the head, register queue_out=addr, load the shift register with data, go to SETUP.
  - Otherwise stay; all outputs hold, and queue_out keeps its last value.
- SETUP: SETUP_CYCLES cycles with data_ctrl_out=0, then SHIFT.
- SHIFT:
  - WORD_W cycles with data_ctrl_out=1.
  - In shift cycle k (0..11), serial_out = data[k], updated on the same edge that enters that cycle. The storer therefore samples bit k on the following edge.
  - Then go to STROBE.
- STROBE: 1 cycle with data_ctrl_out=0, serial_out=0, displaying_trigger_out=0. Then GAP.
- GAP:
  - GAP_CYCLES cycles, outputs idle, queue_out still held.
  - Then follow the IDLE rule directly on exit; the next frame may start without an extra IDLE cycle.
- queue_out is constant from SETUP entry through GAP exit.
- Latency:
  - Push at edge t into empty FIFO with FSM IDLE: pop at edge t+1.
  - data_ctrl_out rises at edge t+1+SETUP_CYCLES.
  - Frame period is SETUP_CYCLES+WORD_W+1+GAP_CYCLES = 17 cycles at defaults.
- hold_in asserted during any non-IDLE state: no effect until the GAP exit decision.
- Counters: the SHIFT bit counter and the phase counter are sized to parameters and reset to 0 on state entry.
- The FIFO pointers wrap modulo FIFO_DEPTH.

Decomposition:
- Shared package/include: WORD_W, ADDR_W defaults and the FSM state encoding. The storer uses the same width constants.
- One sub-module, sel_req_fifo: a synchronous FIFO of ADDR_W+WORD_W bits with push/pop/count/full/empty and the same asynchronous reset.
- The FSM and shift register stay in selection_sender.

Test Plan:
- Single frame, addr=3'b101, data=12'hA5C:
  - queue_out=5 for 2 cycles before ctrl rises;
  - serial bits in order 0,0,1,1,1,0,1,0,0,1,0,1 over 12 ctrl-high cycles;
  - then one trigger-low cycle;
  - a paired storer model shows Hex_display_no=12'hA5C.
- Back-to-back pushes, 4 entries ((0,12'h001), (7,12'hFFF), (2,12'h800), (1,12'h000)):
  - four frames, each 17 cycles, in FIFO order;
  - load_ready_out=0 while count=4;
  - overflow_out stays 0.
- Fifth push while full: load_valid_in held 1 for one cycle with count=4 -> entry not stored, overflow_out=1 and stays 1 until reset.
- hold_in=1 raised mid-SHIFT of frame 1 with 2 entries queued: frame 1 completes, no SETUP starts; dropping hold_in starts the next frame on the following edge.
- Reset pulse in SHIFT cycle 6: outputs return to reset values within the same cycle, fifo_count_out=0, no trigger strobe is issued.
- Push on the same edge as a GAP-exit pop with count=2 -> count stays 2, the next frame starts with no IDLE cycle, queue_out switches at that edge.

Source files
------------

// File: rtl/selection_sender_pkg.sv
// Shared constants and FSM encoding for the selection sender/storer serial link.
// The storer side uses the same word and address widths.
package selection_sender_pkg;

  localparam int SEL_WORD_W = 12;
  localparam int SEL_ADDR_W = 3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_SHIFT,
    ST_STROBE,
    ST_GAP
  } sel_state_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sel_req_fifo.sv
// Request buffer: registered pointers, combinational head; push ignored while full, pop while empty.
// Head data valid the cycle after a push; simultaneous push and pop leaves count unchanged.
module sel_req_fifo #(
  parameter int DATA_W = 15,
  parameter int DEPTH  = 4,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] push_dat,
  input  logic              pop,
  output logic [DATA_W-1:0] pop_dat,
  output logic [PTR_W:0]    count,
  output logic              full,
  output logic              empty
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign full    = (count == (PTR_W+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign pop_dat = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset; entries are only read after being written.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_dat;
  end

endmodule

// File: rtl/selection_sender.sv
// Serialises buffered (addr, word) requests into setup/shift/strobe/gap frames for the storer.
// First ctrl rise SETUP_CYCLES+1 edges after a push into an idle, empty sender; load_ready_out drops when full.
module selection_sender
  import selection_sender_pkg::*;
#(
  parameter int WORD_W       = SEL_WORD_W,
  parameter int ADDR_W       = SEL_ADDR_W,
  parameter int FIFO_DEPTH   = 4,
  parameter int SETUP_CYCLES = 2,
  parameter int GAP_CYCLES   = 2
) (
  input  logic                         ten_MHz_synch_in,
  input  logic                         reset_in,
  input  logic                         load_valid_in,
  output logic                         load_ready_out,
  input  logic [ADDR_W-1:0]            load_addr_in,
  input  logic [WORD_W-1:0]            load_data_in,
  input  logic                         hold_in,
  output logic                         data_ctrl_out,
  output logic                         serial_out,
  output logic [ADDR_W-1:0]            queue_out,
  output logic                         displaying_trigger_out,
  output logic                         busy_out,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_count_out,
  output logic                         overflow_out
);

  localparam int BIT_W = $clog2(WORD_W);
  localparam int PH_W  = $clog2(max_int(SETUP_CYCLES, GAP_CYCLES) + 1);

  sel_state_t               state;
  logic [PH_W-1:0]          ph_cnt;
  logic [BIT_W-1:0]         bit_cnt;
  logic [WORD_W-1:0]        shreg;
  logic [ADDR_W+WORD_W-1:0] head;
  logic                     fifo_full;
  logic                     fifo_empty;
  logic                     push;
  logic                     start;

  assign load_ready_out = !fifo_full;
  assign push           = load_valid_in && !fifo_full;
  assign busy_out       = (state != ST_IDLE);

  // A frame may start from IDLE or straight out of the last GAP cycle.
  assign start = !fifo_empty && !hold_in &&
                 ((state == ST_IDLE) ||
                  ((state == ST_GAP) && (ph_cnt == PH_W'(GAP_CYCLES - 1))));

  sel_req_fifo #(
    .DATA_W (ADDR_W + WORD_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk      (ten_MHz_synch_in),
    .rst      (reset_in),
    .push     (push),
    .push_dat ({load_addr_in, load_data_in}),
    .pop      (start),
    .pop_dat  (head),
    .count    (fifo_count_out),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  always_ff @(posedge ten_MHz_synch_in or posedge reset_in) begin
    if (reset_in) begin
      state                  <= ST_IDLE;
      ph_cnt                 <= '0;
      bit_cnt                <= '0;
      shreg                  <= '0;
      data_ctrl_out          <= 1'b0;
      serial_out             <= 1'b0;
      queue_out              <= '0;
      displaying_trigger_out <= 1'b1;
      overflow_out           <= 1'b0;
    end else begin
      if (load_valid_in && fifo_full) overflow_out <= 1'b1;

      case (state)
        ST_IDLE: begin
          if (start) begin
            queue_out <= head[ADDR_W+WORD_W-1:WORD_W];
            shreg     <= head[WORD_W-1:0];
            ph_cnt    <= '0;
            state     <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          if (ph_cnt == PH_W'(SETUP_CYCLES - 1)) begin
            data_ctrl_out <= 1'b1;
            serial_out    <= shreg[0];
            shreg         <= {1'b0, shreg[WORD_W-1:1]};
            bit_cnt       <= '0;
            state         <= ST_SHIFT;
          end else begin
            ph_cnt <= ph_cnt + PH_W'(1);
          end
        end
        ST_SHIFT: begin
          if (bit_cnt == BIT_W'(WORD_W - 1)) begin
            data_ctrl_out          <= 1'b0;
            serial_out             <= 1'b0;
            displaying_trigger_out <= 1'b0;
            state                  <= ST_STROBE;
          end else begin
            serial_out <= shreg[0];
            shreg      <= {1'b0, shreg[WORD_W-1:1]};
            bit_cnt    <= bit_cnt + BIT_W'(1);
          end
        end
        ST_STROBE: begin
          displaying_trigger_out <= 1'b1;
          ph_cnt                 <= '0;
          state                  <= ST_GAP;
        end
        ST_GAP: begin
          if (start) begin
            queue_out <= head[ADDR_W+WORD_W-1:WORD_W];
            shreg     <= head[WORD_W-1:0];
            ph_cnt    <= '0;
            state     <= ST_SETUP;
          end else if (ph_cnt == PH_W'(GAP_CYCLES - 1)) begin
            state <= ST_IDLE;
          end else begin
            ph_cnt <= ph_cnt + PH_W'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
